// File: rtl/mips_harvard_core.sv
// Single-cycle MIPS-I integer core with separate instruction/data buses.
// One instruction per enabled clock, one branch delay slot, halts on jump to 0.
module mips_harvard_core #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  // Initialisers give a valid power-up state when reset is never asserted.
  logic [31:0] pc_q             = RESET_VECTOR;
  logic        branch_pending_q = 1'b0;
  logic [31:0] branch_target_q  = 32'h0;
  logic        active_q         = 1'b1;
  logic [31:0] gpr_q [32]       = '{default: 32'h0};

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val, sext_imm, zext_imm, pc_plus4, pc_plus8, pc_d;

  assign opcode   = instr_readdata[31:26];
  assign rs       = instr_readdata[25:21];
  assign rt       = instr_readdata[20:16];
  assign rd       = instr_readdata[15:11];
  assign shamt    = instr_readdata[10:6];
  assign funct    = instr_readdata[5:0];
  assign sext_imm = {{16{instr_readdata[15]}}, instr_readdata[15:0]};
  assign zext_imm = {16'h0, instr_readdata[15:0]};
  assign rs_val   = gpr_q[rs];
  assign rt_val   = gpr_q[rt];
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;

  logic        wb_en, take_d, rd_en, wr_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, target_d;

  always_comb begin
    wb_en    = 1'b0;
    wb_addr  = rd;
    wb_data  = 32'h0;
    take_d   = 1'b0;
    target_d = 32'h0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    case (opcode)
      6'h00: begin
        wb_en = 1'b1;
        case (funct)
          6'h00: wb_data = rt_val << shamt;
          6'h02: wb_data = rt_val >> shamt;
          6'h03: wb_data = $signed(rt_val) >>> shamt;
          6'h08: begin wb_en = 1'b0; take_d = 1'b1; target_d = rs_val; end
          6'h09: begin take_d = 1'b1; target_d = rs_val; wb_data = pc_plus8; end
          6'h21: wb_data = rs_val + rt_val;
          6'h23: wb_data = rs_val - rt_val;
          6'h24: wb_data = rs_val & rt_val;
          6'h25: wb_data = rs_val | rt_val;
          6'h26: wb_data = rs_val ^ rt_val;
          6'h27: wb_data = ~(rs_val | rt_val);
          6'h2A: wb_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: wb_data = {31'h0, rs_val < rt_val};
          default: wb_en = 1'b0;
        endcase
      end
      6'h02: begin take_d = 1'b1; target_d = {pc_plus4[31:28], instr_readdata[25:0], 2'b00}; end
      6'h03: begin
        take_d   = 1'b1;
        target_d = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
        wb_en    = 1'b1;
        wb_addr  = 5'd31;
        wb_data  = pc_plus8;
      end
      6'h04: begin take_d = (rs_val == rt_val); target_d = pc_plus4 + {sext_imm[29:0], 2'b00}; end
      6'h05: begin take_d = (rs_val != rt_val); target_d = pc_plus4 + {sext_imm[29:0], 2'b00}; end
      6'h09: begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val + sext_imm; end
      6'h0A: begin wb_en = 1'b1; wb_addr = rt; wb_data = {31'h0, $signed(rs_val) < $signed(sext_imm)}; end
      6'h0B: begin wb_en = 1'b1; wb_addr = rt; wb_data = {31'h0, rs_val < sext_imm}; end
      6'h0C: begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val & zext_imm; end
      6'h0D: begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val | zext_imm; end
      6'h0E: begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val ^ zext_imm; end
      6'h0F: begin wb_en = 1'b1; wb_addr = rt; wb_data = {instr_readdata[15:0], 16'h0}; end
      6'h23: begin wb_en = 1'b1; wb_addr = rt; wb_data = data_readdata; rd_en = 1'b1; end
      6'h2B: wr_en = 1'b1;
      default: ;
    endcase
  end

  // A latched target wins over sequential flow: this edge ends the delay slot.
  assign pc_d = branch_pending_q ? branch_target_q : pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q             <= RESET_VECTOR;
      branch_pending_q <= 1'b0;
      branch_target_q  <= 32'h0;
      active_q         <= 1'b1;
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'h0;
    end else if (clk_enable && active_q) begin
      pc_q             <= pc_d;
      branch_pending_q <= take_d;
      branch_target_q  <= target_d;
      active_q         <= (pc_d != 32'h0);
      if (wb_en && wb_addr != 5'd0) gpr_q[wb_addr] <= wb_data;
    end
  end

  assign active         = active_q;
  assign register_v0    = gpr_q[2];
  assign instr_address  = pc_q;
  assign data_address   = rs_val + sext_imm;
  assign data_writedata = rt_val;
  assign data_read      = rd_en && active_q && clk_enable;
  assign data_write     = wr_en && active_q && clk_enable;

endmodule

// File: tb/tb_mips_harvard_core.sv
// Directed programs for mips_harvard_core with a scoreboard of expected
// memory transactions and final $v0 values.
module tb_mips_harvard_core;
  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic        active;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic        data_write, data_read;

  logic [31:0] imem [8];
  logic [31:0] dmem [16];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_op_t;

  mem_op_t     mem_q[$];
  logic [31:0] v0_q[$];
  int tests = 0;
  int failed = 0;
  int wr_count = 0;

  mips_harvard_core #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .clk_enable(clk_enable), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .data_address(data_address),
    .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  always #5 clk = ~clk;

  assign instr_readdata = (instr_address[31:5] == RV[31:5]) ? imem[instr_address[4:2]] : 32'h0;
  assign data_readdata  = dmem[data_address[5:2]];

  always @(posedge clk) if (data_write) dmem[data_address[5:2]] <= data_writedata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory-bus monitor: every strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (data_write || data_read) begin
      mem_op_t op;
      check("strobe_exclusive", {31'h0, data_write && data_read}, 32'h0);
      check("strobe_expected", {31'h0, mem_q.size() != 0}, 32'h1);
      if (mem_q.size() != 0) begin
        op = mem_q.pop_front();
        check("strobe_kind", {31'h0, data_write}, {31'h0, op.wr});
        check("mem_addr", data_address, op.addr);
        if (op.wr) check("mem_wdata", data_writedata, op.data);
      end
      if (data_write) wr_count++;
      $display("[TB] mem %s addr=%h data=%h", data_write ? "WR" : "RD", data_address,
               data_write ? data_writedata : data_readdata);
    end
  end

  task automatic load(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
    imem[0] = w0; imem[1] = w1; imem[2] = w2; imem[3] = w3;
    imem[4] = w4; imem[5] = w5; imem[6] = w6; imem[7] = w7;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int budget);
    int n = 0;
    logic [31:0] exp_v0;
    while (active && n < budget) begin
      @(negedge clk);
      n++;
    end
    exp_v0 = v0_q.pop_front();
    check({tag, "_halted"}, {31'h0, active}, 32'h0);
    check({tag, "_pc0"}, instr_address, 32'h0);
    check({tag, "_v0"}, register_v0, exp_v0);
    repeat (3) @(negedge clk);
    check({tag, "_v0_stable"}, register_v0, exp_v0);
    check({tag, "_pc_frozen"}, instr_address, 32'h0);
    check({tag, "_memq_empty"}, mem_q.size(), 32'h0);
    $display("[TB] %s: cycles=%0d v0=%h active=%b", tag, n, register_v0, active);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
    // Power-up, no reset: addiu $4,$4,11; sltiu $2,$4,77; jr $0; addiu $0
    load(32'h2484000B, 32'h2C82004D, 32'h00000008, 32'h24000000, 0, 0, 0, 0);
    v0_q.push_back(32'h1);
    #1;
    check("pwr_pc", instr_address, RV);
    check("pwr_active", {31'h0, active}, 32'h1);
    check("pwr_v0", register_v0, 32'h0);
    run_prog("sltiu_true", 20);

    load(32'h2484000B, 32'h2C82000A, 32'h00000008, 32'h24000000, 0, 0, 0, 0);
    v0_q.push_back(32'h0);
    pulse_reset();
    check("rst_pc", instr_address, RV);
    check("rst_active", {31'h0, active}, 32'h1);
    run_prog("sltiu_false", 20);

    // lui $2,0x1234; ori $2,$2,0x5678; jr $0; nop
    load(32'h3C021234, 32'h34425678, 32'h00000008, 32'h0, 0, 0, 0, 0);
    v0_q.push_back(32'h12345678);
    pulse_reset();
    run_prog("lui_ori", 20);

    // lui/ori $4=DEADBEEF; sw $4,0($0); lw $2,0($0); jr $0; nop
    load(32'h3C04DEAD, 32'h3484BEEF, 32'hAC040000, 32'h8C020000, 32'h00000008, 32'h0, 0, 0);
    mem_q.push_back('{wr: 1'b1, addr: 32'h0, data: 32'hDEADBEEF});
    mem_q.push_back('{wr: 1'b0, addr: 32'h0, data: 32'h0});
    v0_q.push_back(32'hDEADBEEF);
    wr_count = 0;
    pulse_reset();
    run_prog("sw_lw", 20);
    check("sw_single_pulse", wr_count, 32'd1);

    // beq $0,$0,+2; addiu $2,$0,5 (slot); addiu $2,$2,100 (skipped); addiu $2,$2,1
    load(32'h10000002, 32'h24020005, 32'h24420064, 32'h24420001, 32'h00000008, 32'h0, 0, 0);
    v0_q.push_back(32'h6);
    pulse_reset();
    run_prog("beq_slot", 20);

    // jal +0x10; addiu $3,$0,-8 (slot); two skipped; sra $2,$3,1; subu $2,$2,$31; jr $0; nop
    load(32'h0FF00004, 32'h2403FFF8, 32'h24020063, 32'h24020063,
         32'h00031043, 32'h005F1023, 32'h00000008, 32'h0);
    v0_q.push_back(32'hFFFFFFFC - (RV + 32'd8));
    pulse_reset();
    run_prog("jal_sra", 20);

    // Stall then reset mid-program with a pending jr $0
    load(32'h3C021234, 32'h34425678, 32'h00000008, 32'h0, 0, 0, 0, 0);
    pulse_reset();
    @(negedge clk);
    check("ce_pc_after_lui", instr_address, RV + 32'd4);
    clk_enable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("ce_hold_pc", instr_address, RV + 32'd4);
      check("ce_hold_v0", register_v0, 32'h12340000);
      check("ce_hold_active", {31'h0, active}, 32'h1);
    end
    clk_enable = 1'b1;
    repeat (2) @(negedge clk);
    check("ce_resume_pc", instr_address, RV + 32'd12);
    check("ce_resume_v0", register_v0, 32'h12345678);
    clk_enable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("ce_rst_pc", instr_address, RV);
    check("ce_rst_v0", register_v0, 32'h0);
    check("ce_rst_active", {31'h0, active}, 32'h1);
    clk_enable = 1'b1;
    @(negedge clk);
    check("ce_pending_dropped", instr_address, RV + 32'd4);
    v0_q.push_back(32'h12345678);
    run_prog("after_reset", 20);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mips_harvard_core.md
Name: mips_harvard_core

Overview:
- Single-cycle, 32-bit big-endian-agnostic MIPS-I integer core with separate instruction and data buses (Harvard).
- Fetches one instruction per enabled clock from a combinational instruction port and executes it in the same cycle, with one branch delay slot.
- Accesses an external word-addressed data memory and halts when control transfers to address 0.
- Exposes register $2 ($v0) for checking.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value after reset and at power-up.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- active  out  1  high while running; low once halted.
- register_v0  out  32  current contents of GPR $2.
- clk_enable  in  1  when low, all architectural state (PC, delay-slot state, GPRs, active) holds.
- instr_address  out  32  PC of the instruction being executed.
- instr_readdata  in  32  instruction at instr_address; combinational, same cycle.
- data_address  out  32  byte address for load/store (rs + sign-extended imm16).
- data_write  out  1  high for SW in the current cycle.
- data_read  out  1  high for LW in the current cycle.
- data_writedata  out  32  rt value for SW.
- data_readdata  in  32  load data; combinational, same cycle as data_address.

Behaviour:
- Reset (sync, active-high): PC=RESET_VECTOR, pending-branch cleared, all 32 GPRs=0, active=1.
- Power-up without reset: same values via register initialisers. The core must run correctly with reset never asserted.
- Datapath: one instruction per enabled rising edge. GPR write-back and PC update occur on that edge.
- $0 always reads 0; writes to it are discarded.
- Delay slot: a taken branch/jump sets next_pc = PC+4 and latches the target. The following instruction executes, then PC = target.
- Supported R-type (opcode 0):
  - ADDU, SUBU, AND, OR, XOR, NOR, SLT (signed), SLTU (unsigned) into rd.
  - SLL, SRL, SRA using shamt.
  - JR rs; JALR rd=PC+8, target=rs.
- Supported I-type:
  - ADDIU and SLTI/SLTIU with sign-extended imm. SLTIU compares unsigned against the sign-extended immediate.
  - ANDI, ORI, XORI with zero-extended imm.
  - LUI rt = imm<<16.
  - LW rt = data_readdata; SW writes rt.
  - BEQ, BNE with target = PC+4+(sext(imm)<<2).
- Supported J-type: J and JAL (target = {PC+4[31:28], imm26, 2'b00}); JAL writes $31 = PC+8.
- Arithmetic: all 32-bit modulo; no overflow traps. Unsupported opcodes execute as NOP.
- Bus strobes: data_read/data_write deasserted for all non-memory instructions. Both strobes are never high together.
- Halt: when PC becomes 0 after a delay slot completes, active goes low on that edge and instr_address reads 0. From then on, no GPR writes, no memory strobes, PC frozen at 0.
- register_v0 is stable and readable while halted.
- clk_enable low mid-program: nothing changes; execution resumes exactly where it stopped.
- Reset asserted mid-operation: takes effect on the next rising edge regardless of clk_enable. Any pending branch is discarded.

Test Plan:
- Power-up with reset never asserted, program at BFC00000: 2484000B (addiu $4,$4,11), 2C82004D (sltiu $2,$4,77), 00000008 (jr $0), 24000000 (delay-slot addiu $0) -> instr_address reaches 0, active=0, register_v0=1.
- Same program with imm 0x000A in sltiu -> register_v0=0 (11 < 10 false); halt still occurs after the delay slot.
- lui $2,0x1234; ori $2,$2,0x5678; jr $0; nop -> register_v0=0x12345678, active=0.
- sw $4,0($0) with $4=0xDEADBEEF, then lw $2,0($0), then jr $0 -> data_write pulses one cycle with data_address=0 and data_writedata=DEADBEEF; register_v0=DEADBEEF.
- beq $0,$0,+2 followed by addiu $2,$0,5 in the delay slot and addiu $2,$2,1 at the target -> delay slot executes, skipped instruction does not execute, register_v0=6.
- Hold clk_enable=0 for 5 cycles mid-program, then assert reset for one cycle -> no state changes while disabled; after reset, PC=BFC00000, GPRs=0, active=1.
